// File: rtl/t_ff_using_d_ff.sv
// Toggle flip-flop bank built from per-bit D flip-flops whose D input is t_in ^ q.
// Every bit toggles independently; reset is asynchronous and active-high.

module d_ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= 1'b0;
      end else begin
         q <= d;
      end
   end

endmodule

module t_ff_using_d_ff #(
   parameter int WIDTH = 1
) (
   output logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] t_in,
   input  logic             rst,
   input  logic             clk
);

   // Feedback term: a set toggle bit inverts the stored value, a clear one reloads it.
   logic [WIDTH-1:0] d_next;

   assign d_next = t_in ^ q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      d_ff u_dff (
         .clk (clk),
         .rst (rst),
         .d   (d_next[i]),
         .q   (q[i])
      );
   end

endmodule

// File: tb/tb_t_ff_using_d_ff.sv
// Bench for t_ff_using_d_ff: a 1-bit and a 4-bit instance driven from a vector table,
// plus hand-written reset sequences; expectations flow through a queue.

module tb_t_ff_using_d_ff;

   typedef struct {
      logic       t1;
      logic [3:0] t4;
      logic       e1;
      logic [3:0] e4;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       t1_in;
   logic [3:0] t4_in;
   logic       q1;
   logic [3:0] q4;

   logic [4:0] exp_q[$];
   vec_t       vecs[$];
   int         checks;
   int         errors;

   t_ff_using_d_ff #(.WIDTH(1)) dut1 (
      .q    (q1),
      .t_in (t1_in),
      .rst  (rst),
      .clk  (clk)
   );

   t_ff_using_d_ff #(.WIDTH(4)) dut4 (
      .q    (q4),
      .t_in (t4_in),
      .rst  (rst),
      .clk  (clk)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got q4=%b q1=%b, expected q4=%b q1=%b at %0t",
                  name, act[4:1], act[0], exp[4:1], exp[0], $time);
      end
   endtask

   task automatic pop_check(input string name);
      logic [4:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: expected queue empty at %0t", name, $time);
      end else begin
         e = exp_q.pop_front();
         check(name, {q4, q1}, e);
      end
   endtask

   // drive on the falling edge, compare one time unit after the rising edge
   task automatic step(input string name, input logic t1, input logic [3:0] t4,
                       input logic e1, input logic [3:0] e4);
      @(negedge clk);
      t1_in = t1;
      t4_in = t4;
      exp_q.push_back({e4, e1});
      @(posedge clk);
      #1;
      pop_check(name);
   endtask

   task automatic add(input logic t1, input logic [3:0] t4, input logic e1, input logic [3:0] e4);
      vec_t v;
      v.t1 = t1;
      v.t4 = t4;
      v.e1 = e1;
      v.e4 = e4;
      vecs.push_back(v);
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // vector table, starting from q1 = 0, q4 = 0
      for (int i = 0; i < 5; i++)  add(1'b0, 4'b0000, 1'b0, 4'b0000);
      for (int i = 0; i < 10; i++) add(1'b1, 4'b0000, (i % 2 == 0), 4'b0000);
      for (int i = 0; i < 11; i++) add(1'b1, 4'b0000, (i % 2 == 0), 4'b0000);
      for (int i = 0; i < 4; i++)  add(1'b0, 4'b0000, 1'b1, 4'b0000);
      add(1'b1, 4'b0000, 1'b0, 4'b0000);
      add(1'b1, 4'b0000, 1'b1, 4'b0000);
      add(1'b0, 4'b0101, 1'b1, 4'b0101);
      add(1'b0, 4'b0101, 1'b1, 4'b0000);
      add(1'b0, 4'b0101, 1'b1, 4'b0101);

      // reset at time 0 with unknown toggle input
      rst   = 1'b1;
      t1_in = 1'bx;
      t4_in = 4'bxxxx;
      #2;
      check("reset_t0", {q4, q1}, 5'b0);
      @(posedge clk);
      #1;
      check("reset_edge_x", {q4, q1}, 5'b0);
      @(negedge clk);
      rst   = 1'b0;
      t1_in = 1'b0;
      t4_in = 4'b0000;
      #1;
      check("release", {q4, q1}, 5'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         step($sformatf("vec%0d", i), vecs[i].t1, vecs[i].t4, vecs[i].e1, vecs[i].e4);
      end

      // async reset between edges with q1 = 1, t_in = 1
      @(negedge clk);
      t1_in = 1'b1;
      t4_in = 4'b1111;
      #1;
      check("no_comb_path", {q4, q1}, {4'b0101, 1'b1});
      #1;
      rst = 1'b1;
      #1;
      check("async_clear", {q4, q1}, 5'b0);
      @(posedge clk);
      #1;
      check("reset_hold_t1", {q4, q1}, 5'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("release_no_toggle", {q4, q1}, 5'b0);
      exp_q.push_back({4'b1111, 1'b1});
      @(posedge clk);
      #1;
      pop_check("first_toggle");
      step("hold_after_reset", 1'b0, 4'b0000, 1'b1, 4'b1111);
      step("toggle_mixed", 1'b1, 4'b1010, 1'b0, 4'b0101);
      step("hold_final", 1'b0, 4'b0000, 1'b0, 4'b0101);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
